// File: rtl/mux_4to1.sv
// mux_4to1: registered 4-to-1 selector.
// One of four WIDTH-bit sources is steered onto the registered output f
// under the 2-bit select {s1, s0}. The datapath is sliced per bit: each bit
// is a plain 4:1 mux lane, and one flop stage sits behind all the lanes.
// The only state in the block is f. There is no enable and no handshake.

// Single-bit 4:1 mux lane. It is purely combinational, so it is one mux level deep.
module mux_4to1_lane (
    input  logic x0,
    input  logic x1,
    input  logic x2,
    input  logic x3,
    input  logic s0,
    input  logic s1,
    output logic y
);

    logic [1:0] sel;

    assign sel = {s1, s0};

    // Pick one lane input by select. The default arm keeps the logic latch-free.
    always_comb begin
        y = x0;
        case (sel)
            2'b00:   y = x0;
            2'b01:   y = x1;
            2'b10:   y = x2;
            2'b11:   y = x3;
            default: y = x0;
        endcase
    end

endmodule

module mux_4to1 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] x0,
    input  logic [WIDTH-1:0] x1,
    input  logic [WIDTH-1:0] x2,
    input  logic [WIDTH-1:0] x3,
    input  logic             s0,
    input  logic             s1,
    output logic [WIDTH-1:0] f
);

    // Next-state value for f. Each bit comes from its own lane instance.
    logic [WIDTH-1:0] d;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_lane
            mux_4to1_lane u_lane (
                .x0 (x0[gi]),
                .x1 (x1[gi]),
                .x2 (x2[gi]),
                .x3 (x3[gi]),
                .s0 (s0),
                .s1 (s1),
                .y  (d[gi])
            );
        end
    endgenerate

    // Output register. Reset wins on its edge, and f then reloads on every
    // non-reset edge. Release needs no recovery cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            f <= '0;
        end else begin
            f <= d;
        end
    end

endmodule

// File: tb/tb_mux_4to1.sv
// Bench for mux_4to1. It instantiates a WIDTH=1 and a WIDTH=8 copy that
// share a clock and reset. Expected outputs are pushed onto a queue when
// stimulus is applied, then popped and compared one edge later.
module tb_mux_4to1;

    logic       clk = 1'b0;
    logic       rst;
    logic       a0, a1, a2, a3, as0, as1;
    logic       fa;
    logic [7:0] b0, b1, b2, b3;
    logic       bs0, bs1;
    logic [7:0] fb;

    int n_chk  = 0;
    int n_fail = 0;

    logic       q1[$];
    logic [7:0] q8[$];

    always #5 clk = ~clk;

    mux_4to1 #(.WIDTH(1)) u_dut1 (
        .clk (clk), .rst (rst),
        .x0 (a0), .x1 (a1), .x2 (a2), .x3 (a3),
        .s0 (as0), .s1 (as1),
        .f  (fa)
    );

    mux_4to1 #(.WIDTH(8)) u_dut8 (
        .clk (clk), .rst (rst),
        .x0 (b0), .x1 (b1), .x2 (b2), .x3 (b3),
        .s0 (bs0), .s1 (bs1),
        .f  (fb)
    );

    // Reference model: a table lookup by index, with reset forcing zero.
    function automatic logic [7:0] ref_f(input logic [7:0] v0, input logic [7:0] v1,
                                         input logic [7:0] v2, input logic [7:0] v3,
                                         input logic t1, input logic t0, input logic r);
        logic [7:0] tbl [4];
        tbl[0] = v0; tbl[1] = v1; tbl[2] = v2; tbl[3] = v3;
        if (r) return 8'h00;
        return tbl[{t1, t0}];
    endfunction

    // Push expectations for the inputs now applied, clock once, then check
    // 1 time unit after the edge.
    task automatic tick(input string tag);
        logic [7:0] e1, e8;
        e1 = ref_f({7'b0, a0}, {7'b0, a1}, {7'b0, a2}, {7'b0, a3}, as1, as0, rst);
        q1.push_back(e1[0]);
        q8.push_back(ref_f(b0, b1, b2, b3, bs1, bs0, rst));
        @(posedge clk);
        #1;
        e1 = {7'b0, q1.pop_front()};
        e8 = q8.pop_front();
        n_chk++;
        assert (fa === e1[0]) else begin
            n_fail++;
            $error("FAIL %s f1 got %b exp %b", tag, fa, e1[0]);
        end
        n_chk++;
        assert (fb === e8) else begin
            n_fail++;
            $error("FAIL %s f8 got %h exp %h", tag, fb, e8);
        end
    endtask

    initial begin
        logic [5:0] v;
        logic [3:0] oh;
        logic       hold1;
        logic [7:0] hold8;

        // Reset, held for two edges with every source at 1 and select 00.
        rst = 1'b1;
        {a3, a2, a1, a0} = 4'b1111; {as1, as0} = 2'b00;
        b0 = 8'hFF; b1 = 8'hFF; b2 = 8'hFF; b3 = 8'hFF; {bs1, bs0} = 2'b00;
        tick("reset0");
        tick("reset1");
        rst = 1'b0;
        tick("reset_release");

        // Select sweep: one-hot data at each position under each select value.
        for (int j = 0; j < 4; j++) begin
            for (int k = 0; k < 4; k++) begin
                oh = 4'b0001 << j;
                {a3, a2, a1, a0} = oh;
                {as1, as0} = k[1:0];
                tick($sformatf("sweep_x%0d_s%0d", j, k));
            end
        end

        // Exhaustive WIDTH=1 sweep. The 8-bit copy gets random data and select meanwhile.
        for (int i = 0; i < 64; i++) begin
            v = i[5:0];
            {a3, a2, a1, a0, as1, as0} = v;
            b0 = 8'($urandom); b1 = 8'($urandom); b2 = 8'($urandom); b3 = 8'($urandom);
            {bs1, bs0} = 2'($urandom_range(0, 3));
            tick($sformatf("exh_%0d", i));
        end

        // Glitch isolation: selects and data move mid-cycle, and f must hold.
        {a3, a2, a1, a0} = 4'b0001; {as1, as0} = 2'b00;
        b0 = 8'h5A; b1 = 8'h00; b2 = 8'h00; b3 = 8'h00; {bs1, bs0} = 2'b00;
        tick("glitch_pre");
        hold1 = 1'b1;
        hold8 = 8'h5A;
        {as1, as0} = 2'b11; {bs1, bs0} = 2'b10;
        b2 = 8'hC3;
        #2;
        n_chk++;
        assert (fa === hold1) else begin
            n_fail++;
            $error("FAIL glitch_f1 got %b exp %b", fa, hold1);
        end
        n_chk++;
        assert (fb === hold8) else begin
            n_fail++;
            $error("FAIL glitch_f8 got %h exp %h", fb, hold8);
        end
        tick("glitch_post");

        // Mid-stream reset of one edge, then selection resumes.
        {a3, a2, a1, a0} = 4'b1111; {as1, as0} = 2'b10;
        tick("mid_pre");
        rst = 1'b1;
        tick("mid_rst");
        rst = 1'b0;
        tick("mid_resume");

        // WIDTH=8 pattern stepping through the select values, then reset.
        b0 = 8'hA5; b1 = 8'h3C; b2 = 8'hF0; b3 = 8'h0F;
        for (int k = 0; k < 4; k++) begin
            {bs1, bs0} = k[1:0];
            tick($sformatf("w8_sel%0d", k));
        end
        rst = 1'b1;
        tick("w8_reset");
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
